pipe_mul: RTL and testbench
===========================

Name: pipe_mul

Overview:
- Fully pipelined, parametrised integer multiplier for the execute stage.
- Accepts one request per cycle and returns results in order after a fixed latency of STAGES cycles.
- Carries a tag per request, supports output backpressure and pipeline flush.
- Selects the low or high half of the product per request, so one unit serves MUL/MULH/MULHSU/MULHU.

Parameters:
- XLEN, 64, operand and result width; any even value 16..64.
- STAGES, 4, pipeline register stages between request acceptance and result; 1..8.
- TAG_W, 5, width of the tag carried alongside each request.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush_i  input  1  discard every in-flight operation
- req_valid_i  input  1  request present
- req_ready_o  output  1  request accepted when req_valid_i and req_ready_o are both high
- op_1_i  input  XLEN  multiplicand
- op_2_i  input  XLEN  multiplier
- op_sel_i  input  2  0=MUL low, 1=MULH s*s, 2=MULHSU s*u, 3=MULHU u*u
- tag_i  input  TAG_W  opaque tag
- resp_valid_o  output  1  result present
- resp_ready_i  input  1  consumer accepts result
- result_o  output  XLEN  selected product half
- tag_o  output  TAG_W  tag of result_o
- busy_o  output  1  any stage holds a valid operation

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; rst has priority over every other input.
- Reset values: all stage valid bits 0, so resp_valid_o=0 and busy_o=0. result_o=0 and tag_o=0.
- Pipeline of STAGES slots, each holding a valid bit, tag, op_sel and intermediate data. The last slot drives the response outputs.
- Advance: advance = !resp_valid_o || resp_ready_i.
  - When advance=1, every slot shifts one step and slot 0 loads the request; its valid bit = req_valid_i.
  - When advance=0, all slots hold and bubbles are not collapsed.
- req_ready_o = advance && !flush_i. This is combinational from resp_valid_o, resp_ready_i and flush_i.
- Latency: a request accepted in cycle N gives resp_valid_o=1 in cycle N+STAGES when no stall occurs. Each stall cycle adds one cycle.
- Throughput: one result per cycle while resp_ready_i=1.
- Order: strictly in order. The tag and op_sel travel unchanged with their operands.
- Arithmetic:
  - op_1 is extended to XLEN+1 bits with sign = (op_sel==1 || op_sel==2).
  - op_2 is extended to XLEN+1 bits with sign = (op_sel==1).
  - The product is computed exactly over 2*XLEN bits.
  - result_o = product[XLEN-1:0] for op_sel 0, else product[2*XLEN-1:XLEN].
  - The internal structure (radix-4 Booth, CSA tree, final adder) and how it is split across stages are free. The latency is fixed.
- Flush:
  - When flush_i=1, all valid bits clear at the next edge and no request is accepted in that cycle.
  - resp_valid_o=0 from the following cycle.
  - A result shown together with flush_i is not consumed, even if resp_ready_i=1.
- Reset mid-operation: the same as a flush. All in-flight work is lost and no response is produced.
- busy_o = OR of all slot valid bits, output slot included.
- result_o and tag_o hold their value while resp_valid_o=1 and resp_ready_i=0. They are don't-care when resp_valid_o=0.

Optional Feature:
- Macro: PIPE_MUL_WORD_EN.
- When defined:
  - Adds input word_i (1 bit), which travels with the request.
  - With word_i=1, only op_1_i[31:0] and op_2_i[31:0] are used.
  - result_o = sign-extension to XLEN of product[31:0] (RV64 MULW); op_sel_i is ignored.
  - word_i=0 gives the normal behaviour.
  - Latency is unchanged.
- When undefined: no word_i port, no extra logic.

Test Plan (XLEN=64, STAGES=4):
- Basic ops, one request each:
  - MUL 3*5 -> 0xF exactly 4 cycles after acceptance.
  - MULH 0xFFFF_FFFF_FFFF_FFFF*0xFFFF_FFFF_FFFF_FFFF -> 0.
  - MULHU, same operands -> 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU, same operands -> 0xFFFF_FFFF_FFFF_FFFF.
  - MULH 0x8000_0000_0000_0000*0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000.
- Throughput: 16 back-to-back random requests with tags 0..15 and resp_ready_i=1 -> 16 consecutive responses, in tag order, matching the reference model; req_ready_o stays 1.
- Backpressure: pipe full, then resp_ready_i=0 for 5 cycles -> req_ready_o=0, result_o and tag_o stable. On release, responses resume in order with no loss or duplication.
- Flush: 3 requests in flight, flush_i pulsed while resp_valid_o=1 -> no responses after the flush; busy_o=0 next cycle; the next request gets its result 4 cycles after acceptance.
- Reset: rst asserted with 4 operations in flight -> resp_valid_o=0 and busy_o=0 after the edge; no stale results appear afterwards.
- PIPE_MUL_WORD_EN only: word_i=1, op_1=0x7FFF_FFFF, op_2=2 -> 0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/pipe_mul.sv
// pipe_mul: fully pipelined XLEN x XLEN multiplier (MUL/MULH/MULHSU/MULHU) with tag, backpressure and flush.
// Optional RV64 MULW support is compiled in when the macro PIPE_MUL_WORD_EN is defined (adds word_i).
module pipe_mul #(
    parameter int XLEN   = 64,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  op_1_i,
    input  logic [XLEN-1:0]  op_2_i,
    input  logic [1:0]       op_sel_i,
    input  logic [TAG_W-1:0] tag_i,
`ifdef PIPE_MUL_WORD_EN
    input  logic             word_i,
`endif
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int PW = 2 * XLEN;
    localparam int HX = XLEN / 2;

    // Slot 0 holds two partial products; slot 1 onwards holds their sum in lo (hi is zero).
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       sel;
        logic             word;
        logic [PW-1:0]    lo;
        logic [PW-1:0]    hi;
    } slot_t;

    slot_t           pipe [STAGES];
    slot_t           head;
    slot_t           last;
    logic            advance;
    logic            word_in;
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_in, b_in;
    logic [XLEN:0]   a_x, b_x;
    logic [PW-1:0]   a_w, blo_w, bhi_w, prod;

`ifdef PIPE_MUL_WORD_EN
    assign word_in = word_i;
`else
    assign word_in = 1'b0;
`endif

    assign last         = pipe[STAGES-1];
    assign advance      = !last.valid || resp_ready_i;
    assign req_ready_o  = advance && !flush_i;
    assign resp_valid_o = last.valid;
    assign tag_o        = last.tag;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        a_in  = op_1_i;
        b_in  = op_2_i;
        a_sgn = (op_sel_i == 2'd1) || (op_sel_i == 2'd2);
        b_sgn = (op_sel_i == 2'd1);
        if (word_in) begin
            // Low 32 product bits only depend on low 32 operand bits, so extension is irrelevant.
            a_in  = XLEN'(op_1_i[31:0]);
            b_in  = XLEN'(op_2_i[31:0]);
            a_sgn = 1'b0;
            b_sgn = 1'b0;
        end
        a_x   = {a_sgn & a_in[XLEN-1], a_in};
        b_x   = {b_sgn & b_in[XLEN-1], b_in};
        a_w   = {{(XLEN-1){a_x[XLEN]}}, a_x};
        blo_w = PW'(b_x[HX-1:0]);
        bhi_w = {{(PW-HX-1){b_x[XLEN]}}, b_x[XLEN:HX]};

        head       = '0;
        head.valid = req_valid_i;
        head.tag   = tag_i;
        head.sel   = op_sel_i;
        head.word  = word_in;
        head.lo    = a_w * blo_w;
        head.hi    = (a_w * bhi_w) << HX;
    end

    // NOTE: sequential state uses non-blocking assignments so every slot samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath is reset along with the valid bits so result_o and tag_o read 0 out of reset.
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            if (advance) begin
                pipe[0] <= head;
                for (int i = 1; i < STAGES; i++) begin
                    pipe[i] <= pipe[i-1];
                    if (i == 1) begin
                        pipe[i].lo <= pipe[i-1].lo + pipe[i-1].hi;
                        pipe[i].hi <= '0;
                    end
                end
            end
            if (flush_i) begin
                for (int i = 0; i < STAGES; i++) pipe[i].valid <= 1'b0;
            end
        end
    end

    assign prod = (STAGES == 1) ? last.lo + last.hi : last.lo;

    always_comb begin
        result_o = (last.sel == 2'd0) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        if (last.word) result_o = XLEN'($signed(prod[31:0]));
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < STAGES; i++) busy_o = busy_o | pipe[i].valid;
    end

endmodule

// File: tb/tb_pipe_mul.sv
// tb_pipe_mul: scoreboard bench for pipe_mul (XLEN=64, STAGES=4); define PIPE_MUL_WORD_EN to also test MULW.
module tb_pipe_mul;

    localparam int XLEN   = 64;
    localparam int STAGES = 4;
    localparam int TAG_W  = 5;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
        int               acc;
        bit               lat;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst, flush_i, req_valid_i, req_ready_o;
    logic [XLEN-1:0]  op_1_i, op_2_i, result_o;
    logic [1:0]       op_sel_i;
    logic [TAG_W-1:0] tag_i, tag_o;
    logic             word_i;
    logic             resp_valid_o, resp_ready_i, busy_o;

    entry_t sb [$];
    entry_t mon_e;
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     n_resp = 0;
    int     last_resp_cyc = 0;
    int     last_acc_cyc = 0;
    int     last_waits = 0;

    pipe_mul #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_1_i       (op_1_i),
        .op_2_i       (op_2_i),
        .op_sel_i     (op_sel_i),
        .tag_i        (tag_i),
`ifdef PIPE_MUL_WORD_EN
        .word_i       (word_i),
`endif
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .tag_o        (tag_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Exact reference product over 130 signed bits.
    function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [1:0] sel, input bit w);
        logic signed [XLEN:0]     ax, bx;
        logic signed [2*XLEN+1:0] p;
        logic [63:0]              p32;
        if (w) begin
            p32 = {32'd0, a[31:0]} * {32'd0, b[31:0]};
            return {{(XLEN-32){p32[31]}}, p32[31:0]};
        end
        ax = (sel == 2'd1 || sel == 2'd2) ? $signed({a[XLEN-1], a}) : $signed({1'b0, a});
        bx = (sel == 2'd1) ? $signed({b[XLEN-1], b}) : $signed({1'b0, b});
        p  = ax * bx;
        return (sel == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Response side: pop and compare every consumed result.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid_o && resp_ready_i && !flush_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_tag", tag_o, mon_e.tag);
                    check("resp_result", result_o, mon_e.res);
                    if (mon_e.lat) check("latency", cyc - mon_e.acc, STAGES);
                end
                n_resp++;
                last_resp_cyc = cyc;
            end
            if (flush_i) sb.delete();
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [1:0] sel,
                        input logic [TAG_W-1:0] t, input logic [XLEN-1:0] exp, input bit lat, input bit w);
        entry_t e;
        bit     done = 0;
        req_valid_i = 1'b1;
        op_1_i = a; op_2_i = b; op_sel_i = sel; tag_i = t; word_i = w;
        last_waits = 0;
        while (!done && last_waits < 50) begin
            @(negedge clk);
            if (req_ready_o) begin
                e.tag = t; e.res = exp; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
                last_acc_cyc = cyc;
                done = 1;
            end else begin
                last_waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 1, 0);
        req_valid_i = 1'b0;
        word_i = 1'b0;
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] t, input bit lat);
        logic [XLEN-1:0] a, b;
        logic [1:0]      sel;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sel = 2'($urandom_range(0, 3));
        send(a, b, sel, t, model(a, b, sel, 1'b0), lat, 1'b0);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy_o) done = 1;
        end
        if (!done) check("drain_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_resp_valid();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (resp_valid_o) done = 1;
        end
        if (!done) check("resp_valid_timeout", 1, 0);
    endtask

    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MSB  = {1'b1, {(XLEN-1){1'b0}}};

    initial begin
        logic [XLEN-1:0]  cap_res;
        logic [TAG_W-1:0] cap_tag;
        int               t0, r0;

        rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
        op_1_i = '0; op_2_i = '0; op_sel_i = '0; tag_i = '0; word_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_result", result_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_req_ready", req_ready_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed ops with known products
        send(64'd3, 64'd5, 2'd0, 5'd1, 64'hF, 1, 0);
        wait_drain();
        send(ONES, ONES, 2'd1, 5'd2, 64'h0, 1, 0);
        send(ONES, ONES, 2'd3, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
        send(ONES, ONES, 2'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        send(MSB, MSB, 2'd1, 5'd5, 64'h4000_0000_0000_0000, 1, 0);
        wait_drain();

        // Back-to-back throughput
        r0 = n_resp;
        for (int i = 0; i < 16; i++) begin
            send_rand(TAG_W'(i), 1);
            check("b2b_ready_waits", last_waits, 0);
            if (i == 0) t0 = last_acc_cyc;
        end
        wait_drain();
        check("b2b_count", n_resp - r0, 16);
        check("b2b_span", last_resp_cyc - t0, STAGES + 15);

        // Backpressure
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(TAG_W'(20 + i), 0);
        wait_resp_valid();
        cap_res = result_o;
        cap_tag = tag_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_ready", req_ready_o, 0);
            check("stall_result", result_o, cap_res);
            check("stall_tag", tag_o, cap_tag);
        end
        @(posedge clk); #1;
        r0 = n_resp;
        resp_ready_i = 1'b1;
        wait_drain();
        check("stall_resp_count", n_resp - r0, 4);

        // Flush while a result is presented
        for (int i = 0; i < 3; i++) send_rand(TAG_W'(8 + i), 0);
        wait_resp_valid();
        @(posedge clk); #1;
        flush_i = 1'b1;
        req_valid_i = 1'b1; op_1_i = 64'd7; op_2_i = 64'd9; op_sel_i = 2'd0; tag_i = 5'd31;
        @(negedge clk);
        check("flush_resp_shown", resp_valid_o, 1);
        check("flush_req_ready", req_ready_o, 0);
        @(posedge clk); #1;
        flush_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        check("flush_busy", busy_o, 0);
        check("flush_resp_valid", resp_valid_o, 0);
        r0 = n_resp;
        repeat (8) @(negedge clk);
        check("flush_no_resp", n_resp - r0, 0);
        @(posedge clk); #1;
        send(64'd6, 64'd7, 2'd0, 5'd12, 64'd42, 1, 0);
        wait_drain();

        // Reset with four operations in flight
        for (int i = 0; i < 4; i++) send_rand(TAG_W'(16 + i), 0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_resp_valid", resp_valid_o, 0);
        check("rst_mid_busy", busy_o, 0);
        r0 = n_resp;
        repeat (8) @(negedge clk);
        check("rst_mid_no_resp", n_resp - r0, 0);
        @(posedge clk); #1;

`ifdef PIPE_MUL_WORD_EN
        send(64'h7FFF_FFFF, 64'd2, 2'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
        send(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0003, 2'd3, 5'd8,
             model(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0003, 2'd3, 1'b1), 1, 1);
        wait_drain();
`endif

        // Mixed random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand(TAG_W'(i), 0);
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    @(posedge clk); #2;
                    resp_ready_i = ($urandom_range(0, 3) != 0);
                end
                resp_ready_i = 1'b1;
            end
        join
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
